// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus between the IF/ID front end (master) and ctrl_pipe_unit (slave).
// Valid_i qualifies Op_i for one cycle; there is no back-pressure, and MemStall_i freezes the pipe instead.
interface ctrl_pipe_if #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
);
    logic               Valid_i;
    logic [6:0]         Op_i;
    logic               NoOp_i;
    logic               Flush_i;
    logic               MemStall_i;
    logic               ClrIllegal_i;
    logic [ALUOP_W-1:0] ALUOp_ex_o;
    logic               ALUSrc_ex_o;
    logic               Branch_ex_o;
    logic               Jump_ex_o;
    logic               MemRead_ex_o;
    logic               MemRead_mem_o;
    logic               MemWrite_mem_o;
    logic               RegWrite_mem_o;
    logic               RegWrite_wb_o;
    logic               MemtoReg_wb_o;
    logic               Illegal_o;
    logic [CNT_W-1:0]   RetireCnt_o;
    logic [CNT_W-1:0]   BubbleCnt_o;

    modport master (
        output Valid_i, Op_i, NoOp_i, Flush_i, MemStall_i, ClrIllegal_i,
        input  ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, Jump_ex_o, MemRead_ex_o,
               MemRead_mem_o, MemWrite_mem_o, RegWrite_mem_o, RegWrite_wb_o,
               MemtoReg_wb_o, Illegal_o, RetireCnt_o, BubbleCnt_o
    );

    modport slave (
        input  Valid_i, Op_i, NoOp_i, Flush_i, MemStall_i, ClrIllegal_i,
        output ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, Jump_ex_o, MemRead_ex_o,
               MemRead_mem_o, MemWrite_mem_o, RegWrite_mem_o, RegWrite_wb_o,
               MemtoReg_wb_o, Illegal_o, RetireCnt_o, BubbleCnt_o
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control decoder: decodes the ID opcode and carries control through ID/EX, EX/MEM, MEM/WB.
// Define CTRL_JAL_EN to additionally decode jal/jalr and drive Jump_ex_o.
module ctrl_pipe_unit #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ctrl_pipe_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] aluOp;
        logic               aluSrc;
        logic               regWrite;
        logic               memtoReg;
        logic               memRead;
        logic               memWrite;
        logic               branch;
`ifdef CTRL_JAL_EN
        logic               jump;
`endif
    } exCtrl_t;

    typedef struct packed {
        logic valid;
        logic regWrite;
        logic memtoReg;
        logic memRead;
        logic memWrite;
    } memCtrl_t;

    typedef struct packed {
        logic valid;
        logic regWrite;
        logic memtoReg;
    } wbCtrl_t;

    exCtrl_t          dec;
    logic             decIllegal;
    exCtrl_t          idNext;
    exCtrl_t          idEx;
    memCtrl_t         exMem;
    wbCtrl_t          memWb;
    logic             illegalQ;
    logic [CNT_W-1:0] retireCnt;
    logic [CNT_W-1:0] bubbleCnt;
    logic             advance;
    logic             squash;
    logic             setIllegal;
    logic             addBubble;

    always_comb begin
        dec        = '0;
        decIllegal = 1'b0;
        case (bus.Op_i)
            7'b0110011: begin
                dec.aluOp    = ALUOP_W'(2'b10);
                dec.regWrite = 1'b1;
            end
            7'b0010011: begin
                dec.aluOp    = ALUOP_W'(2'b11);
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            7'b0000011: begin
                dec.aluOp    = ALUOP_W'(2'b11);
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.memtoReg = 1'b1;
                dec.memRead  = 1'b1;
            end
            7'b0100011: begin
                dec.aluOp    = ALUOP_W'(2'b00);
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            7'b1100011: begin
                dec.aluOp    = ALUOP_W'(2'b01);
                dec.branch   = 1'b1;
            end
`ifdef CTRL_JAL_EN
            7'b1101111: begin
                dec.aluOp    = ALUOP_W'(2'b00);
                dec.regWrite = 1'b1;
                dec.jump     = 1'b1;
            end
            7'b1100111: begin
                dec.aluOp    = ALUOP_W'(2'b11);
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
                dec.jump     = 1'b1;
            end
`endif
            default: decIllegal = 1'b1;
        endcase
    end

    // An unknown opcode only counts as illegal when a real, non-squashed instruction carries it.
    always_comb begin
        advance    = !bus.MemStall_i;
        squash     = bus.NoOp_i | bus.Flush_i | decIllegal;
        setIllegal = advance & bus.Valid_i & !bus.NoOp_i & !bus.Flush_i & decIllegal;
        addBubble  = advance & bus.Valid_i & squash;
        idNext     = '0;
        if (bus.Valid_i && !squash) begin
            idNext       = dec;
            idNext.valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idEx      <= '0;
            exMem     <= '0;
            memWb     <= '0;
            retireCnt <= '0;
            bubbleCnt <= '0;
        end else if (advance) begin
            idEx           <= idNext;
            exMem.valid    <= idEx.valid;
            exMem.regWrite <= idEx.regWrite;
            exMem.memtoReg <= idEx.memtoReg;
            exMem.memRead  <= idEx.memRead;
            exMem.memWrite <= idEx.memWrite;
            memWb.valid    <= exMem.valid;
            memWb.regWrite <= exMem.regWrite;
            memWb.memtoReg <= exMem.memtoReg;
            if (memWb.valid && !(&retireCnt)) retireCnt <= retireCnt + CNT_ONE;
            if (addBubble && !(&bubbleCnt))   bubbleCnt <= bubbleCnt + CNT_ONE;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                illegalQ <= 1'b0;
        else if (setIllegal)       illegalQ <= 1'b1;
        else if (bus.ClrIllegal_i) illegalQ <= 1'b0;
    end

    assign bus.ALUOp_ex_o     = idEx.aluOp;
    assign bus.ALUSrc_ex_o    = idEx.aluSrc;
    assign bus.Branch_ex_o    = idEx.branch;
`ifdef CTRL_JAL_EN
    assign bus.Jump_ex_o      = idEx.jump;
`else
    assign bus.Jump_ex_o      = 1'b0;
`endif
    assign bus.MemRead_ex_o   = idEx.memRead;
    assign bus.MemRead_mem_o  = exMem.memRead;
    assign bus.MemWrite_mem_o = exMem.memWrite;
    assign bus.RegWrite_mem_o = exMem.regWrite;
    assign bus.RegWrite_wb_o  = memWb.regWrite;
    assign bus.MemtoReg_wb_o  = memWb.memtoReg;
    assign bus.Illegal_o      = illegalQ;
    assign bus.RetireCnt_o    = retireCnt;
    assign bus.BubbleCnt_o    = bubbleCnt;
endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Parametrised successor to the single-cycle combinational control decoder. Decodes the ID-stage opcode and carries the resulting control bundle through internal ID/EX, EX/MEM and MEM/WB control registers. Handles bubble insertion, branch flush and cache-miss freeze, flags illegal opcodes, and keeps retire/bubble performance counters. Sits between the IF/ID register and the EX/MEM/WB datapath; the datapath pipeline registers no longer carry control bits.

Parameters:
ALUOP_W, 2, ALUOp field width (>=2); decoded codes are zero-extended.
CNT_W, 32, width of the retire and bubble counters (saturating).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
Valid_i  in  1  IF/ID holds a real instruction
Op_i  in  7  opcode of the ID-stage instruction
NoOp_i  in  1  hazard unit requests a bubble (load-use)
Flush_i  in  1  squash the ID-stage instruction (taken branch)
MemStall_i  in  1  data-cache busy; freeze all control stages
ClrIllegal_i  in  1  clear the sticky illegal flag
ALUOp_ex_o  out  ALUOP_W  EX-stage ALU op class
ALUSrc_ex_o  out  1  EX-stage immediate select
Branch_ex_o  out  1  EX-stage branch
Jump_ex_o  out  1  EX-stage jump (see Optional Feature)
MemRead_ex_o  out  1  EX-stage load, for the hazard unit
MemRead_mem_o  out  1  MEM-stage read strobe
MemWrite_mem_o  out  1  MEM-stage write strobe
RegWrite_mem_o  out  1  MEM-stage regwrite, for forwarding
RegWrite_wb_o  out  1  WB-stage register write enable
MemtoReg_wb_o  out  1  WB-stage writeback select
Illegal_o  out  1  sticky illegal-opcode flag
RetireCnt_o  out  CNT_W  valid instructions leaving WB
BubbleCnt_o  out  CNT_W  bubbles inserted into ID/EX

Behaviour:
- Decode (ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch):
  - 0110011 R-type: 10, 0, 1, 0, 0, 0, 0
  - 0010011 I-arith: 11, 1, 1, 0, 0, 0, 0
  - 0000011 lw: 11, 1, 1, 1, 1, 0, 0
  - 0100011 sw: 00, 1, 0, 0, 0, 1, 0
  - 1100011 beq: 01, 0, 0, 0, 0, 0, 1
- Any other opcode decodes to all-zero and is illegal. No latching of previous values; no X outputs.
- Each stage register holds a valid bit plus its control fields.
- Reset (rst_i low, async): all stage registers, valid bits, counters and Illegal_o go to 0. All outputs read 0 while reset is asserted.
- Any signal applied during reset is ignored. Releasing reset mid-stream restarts from an empty pipe.
- MemStall_i=1 has priority over everything:
  - All three stages hold.
  - Counters hold.
  - Illegal_o does not set.
  - NoOp_i and Flush_i are ignored that cycle.
- Otherwise, each cycle:
  - ID/EX <= bubble if (!Valid_i | NoOp_i | Flush_i | illegal), else the decoded bundle with valid=1.
  - EX/MEM <= ID/EX.
  - MEM/WB <= EX/MEM.
- Bubble = all control fields 0, valid 0.
- Latency: control for an instruction in ID at cycle n appears at the EX outputs at n+1, MEM at n+2, WB at n+3.
- If NoOp_i and Flush_i are both high, one bubble is inserted and BubbleCnt increments once.
- BubbleCnt_o increments on each non-stalled cycle with Valid_i & (NoOp_i | Flush_i | illegal). Saturates at all-ones.
- RetireCnt_o increments on each non-stalled cycle in which MEM/WB valid=1. Saturates at all-ones.
- Illegal_o sets on a non-stalled cycle with Valid_i & !NoOp_i & !Flush_i & unknown opcode.
- ClrIllegal_i clears Illegal_o. If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: CTRL_JAL_EN.
- Defined: also decode
  - 1101111 jal: ALUOp 00, ALUSrc 0, RegWrite 1, MemtoReg 0, Jump 1.
  - 1100111 jalr: ALUOp 11, ALUSrc 1, RegWrite 1, MemtoReg 0, Jump 1.
- Jump_ex_o follows the pipe like Branch.
- Undefined: both opcodes are illegal (bubble + Illegal_o), and Jump_ex_o is constant 0.

Test Plan:
- Reset then stream R, lw, sw, beq with Valid_i=1 -> EX outputs 10/0, 11/1, 00/1, 01/0 on cycles 1-4. MemRead_mem_o=1 at cycle 3 only. RegWrite_wb_o=1 at cycles 3 and 4. RetireCnt_o=4 after 7 cycles.
- lw then NoOp_i=1 for one cycle -> MemRead_ex_o=1 then a zero EX bundle. BubbleCnt_o=1. Subsequent instruction delayed one cycle.
- MemStall_i=1 for 5 cycles with sw in MEM -> MemWrite_mem_o held 1 all 5 cycles. Counters unchanged. Pipe advances on the first cycle after MemStall_i drops.
- Op_i=1111111 with Valid_i=1 -> bubble, Illegal_o=1 next cycle. Stays 1 until ClrIllegal_i pulse; simultaneous new illegal op keeps it 1.
- Assert rst_i low mid-stream with all stages valid -> all outputs 0 immediately (async). After release, first valid instruction reaches WB 3 cycles later.
- Op_i=1101111 -> Jump_ex_o=1, RegWrite_wb_o=1 with CTRL_JAL_EN defined; Illegal_o=1 and Jump_ex_o=0 without it.
